ddr3_stream_reader: RTL and testbench

DDR3_STREAM_READER -- requirements
Module: ddr3_stream_reader

---
 rtl/ddr3_stream_reader.sv | 245 ++++++++++++++++++++++++
 tb/tb_ddr3_stream_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_stream_reader.sv
// Streams a linear DDR3 address range through the MIG read port and emits it
// as 16-bit words, buffering whole 128-bit bursts in a small internal FIFO.
module ddr3_stream_reader #(
   parameter logic [26:0] START_ADDR = 27'h0000000,
   parameter logic [26:0] END_ADDR   = 27'h0100000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ram_init_done,
   output logic [26:0] ram_address,
   output logic [2:0]  ram_cmd,
   output logic        ram_en,
   input  logic        ram_rdy,
   input  logic [63:0] ram_rd_data,
   input  logic        ram_rd_data_valid,
   input  logic        ram_rd_data_end,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        rd_error
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_LAST) begin
         ptr_inc = {PTR_W{1'b0}};
      end else begin
         ptr_inc = p + PTR_W'(1);
      end
   endfunction

   function automatic logic [15:0] word_sel(input logic [127:0] entry, input logic [2:0] k);
      word_sel = entry[{k, 4'b0000} +: 16];
   endfunction

   state_t             state_r, state_nxt_s;
   logic [26:0]        addr_r, addr_nxt_s;
   logic [CNT_W-1:0]   outstanding_r, outstanding_nxt_s;
   logic [CNT_W-1:0]   fifo_count_r, fifo_count_nxt_s, count_after_pop_s;
   logic [PTR_W-1:0]   rd_ptr_r, rd_ptr_nxt_s;
   logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_nxt_s;
   logic [2:0]         word_idx_r, word_idx_nxt_s;
   logic               pending_r, pending_nxt_s;
   logic [63:0]        first_beat_r, first_beat_nxt_s;
   logic [127:0]       fifo_mem_r [FIFO_DEPTH];
   logic [127:0]       push_data_s, head_s;
   logic               ram_en_r, ram_en_nxt_s;
   logic               out_valid_r, out_valid_nxt_s;
   logic [15:0]        out_data_r, out_data_nxt_s;
   logic               busy_r, busy_nxt_s;
   logic               done_r, done_nxt_s;
   logic               rd_error_r, rd_error_nxt_s;
   logic               accept_s, push_s, fifo_wr_s, dec_s, beat_err_s, full_err_s;
   logic               consume_s, pop_s;

   assign ram_cmd     = 3'b001;
   assign ram_address = addr_r;
   assign ram_en      = ram_en_r;
   assign out_data    = out_data_r;
   assign out_valid   = out_valid_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign rd_error    = rd_error_r;

   assign push_data_s = {first_beat_r, ram_rd_data};

   // Next-state logic: beat assembly, FIFO bookkeeping, FSM and registered outputs.
   always_comb begin
      state_nxt_s      = state_r;
      addr_nxt_s       = addr_r;
      pending_nxt_s    = pending_r;
      first_beat_nxt_s = first_beat_r;
      push_s           = 1'b0;
      dec_s            = 1'b0;
      beat_err_s       = 1'b0;
      full_err_s       = 1'b0;
      fifo_wr_s        = 1'b0;

      accept_s  = ram_en_r && ram_rdy;
      consume_s = out_valid_r && out_ready;
      pop_s     = consume_s && (word_idx_r == 3'd7);

      // Beats only count against an outstanding command; anything else is dropped and flagged.
      if (ram_rd_data_valid) begin
         if (outstanding_r == {CNT_W{1'b0}}) begin
            beat_err_s = 1'b1;
         end else if (ram_rd_data_end) begin
            if (pending_r) begin
               push_s        = 1'b1;
               dec_s         = 1'b1;
               pending_nxt_s = 1'b0;
            end else begin
               beat_err_s = 1'b1;
            end
         end else begin
            if (pending_r) begin
               beat_err_s = 1'b1;
            end else begin
               pending_nxt_s    = 1'b1;
               first_beat_nxt_s = ram_rd_data;
            end
         end
      end else begin
         beat_err_s = 1'b0;
      end

      if (push_s && (fifo_count_r == DEPTH_C) && !pop_s) begin
         full_err_s = 1'b1;
      end else begin
         fifo_wr_s = push_s;
      end

      word_idx_nxt_s    = consume_s ? (word_idx_r + 3'd1) : word_idx_r;
      rd_ptr_nxt_s      = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      wr_ptr_nxt_s      = fifo_wr_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      count_after_pop_s = pop_s ? (fifo_count_r - CNT_ONE) : fifo_count_r;
      fifo_count_nxt_s  = fifo_wr_s ? (count_after_pop_s + CNT_ONE) : count_after_pop_s;
      outstanding_nxt_s = outstanding_r;
      if (accept_s && !dec_s) begin
         outstanding_nxt_s = outstanding_r + CNT_ONE;
      end else if (!accept_s && dec_s) begin
         outstanding_nxt_s = outstanding_r - CNT_ONE;
      end else begin
         outstanding_nxt_s = outstanding_r;
      end

      case (state_r)
         IDLE, DONE: begin
            if (start && ram_init_done) begin
               if (START_ADDR >= END_ADDR) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = ISSUE;
                  addr_nxt_s  = START_ADDR;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         ISSUE: begin
            if (accept_s) begin
               addr_nxt_s = addr_r + 27'd8;
               if (({1'b0, addr_r} + 28'd8) >= {1'b0, END_ADDR}) begin
                  state_nxt_s = DRAIN;
               end else begin
                  state_nxt_s = ISSUE;
               end
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         DRAIN: begin
            if ((outstanding_r == {CNT_W{1'b0}}) && (fifo_count_r == {CNT_W{1'b0}}) && !pending_r) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase

      // The head entry is the incoming burst when it lands in an otherwise empty buffer.
      if (fifo_wr_s && (count_after_pop_s == {CNT_W{1'b0}})) begin
         head_s = push_data_s;
      end else begin
         head_s = fifo_mem_r[rd_ptr_nxt_s];
      end

      if (fifo_count_nxt_s != {CNT_W{1'b0}}) begin
         out_data_nxt_s = word_sel(head_s, word_idx_nxt_s);
      end else begin
         out_data_nxt_s = out_data_r;
      end

      out_valid_nxt_s = (fifo_count_nxt_s != {CNT_W{1'b0}});
      ram_en_nxt_s    = (state_nxt_s == ISSUE) &&
                        (({1'b0, outstanding_nxt_s} + {1'b0, fifo_count_nxt_s}) < {1'b0, DEPTH_C});
      busy_nxt_s      = (state_nxt_s == ISSUE) || (state_nxt_s == DRAIN);
      done_nxt_s      = (state_nxt_s == DONE);
      rd_error_nxt_s  = rd_error_r || beat_err_s || full_err_s;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         addr_r        <= 27'd0;
         outstanding_r <= {CNT_W{1'b0}};
         fifo_count_r  <= {CNT_W{1'b0}};
         rd_ptr_r      <= {PTR_W{1'b0}};
         wr_ptr_r      <= {PTR_W{1'b0}};
         word_idx_r    <= 3'd0;
         pending_r     <= 1'b0;
         first_beat_r  <= 64'd0;
         ram_en_r      <= 1'b0;
         out_valid_r   <= 1'b0;
         out_data_r    <= 16'd0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         rd_error_r    <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         addr_r        <= addr_nxt_s;
         outstanding_r <= outstanding_nxt_s;
         fifo_count_r  <= fifo_count_nxt_s;
         rd_ptr_r      <= rd_ptr_nxt_s;
         wr_ptr_r      <= wr_ptr_nxt_s;
         word_idx_r    <= word_idx_nxt_s;
         pending_r     <= pending_nxt_s;
         first_beat_r  <= first_beat_nxt_s;
         ram_en_r      <= ram_en_nxt_s;
         out_valid_r   <= out_valid_nxt_s;
         out_data_r    <= out_data_nxt_s;
         busy_r        <= busy_nxt_s;
         done_r        <= done_nxt_s;
         rd_error_r    <= rd_error_nxt_s;
      end
   end

   // Burst storage; contents are only meaningful below fifo_count.
   always_ff @(posedge clk) begin
      if (fifo_wr_s) begin
         fifo_mem_r[wr_ptr_r] <= push_data_s;
      end
   end

endmodule

// File: tb/tb_ddr3_stream_reader.sv
// Randomized bench: a MIG memory model returns bursts for accepted commands and
// the output stream is compared against the memory contents in address order.
module tb_ddr3_stream_reader;

   localparam logic [26:0] S_ADDR  = 27'd0;
   localparam logic [26:0] E_ADDR  = 27'd256;
   localparam int          DEPTH   = 4;
   localparam int          N_WORDS = 256;
   localparam int          N_CMDS  = 32;

   logic        clk = 1'b0;
   logic        reset, start, start_e, ram_init_done;
   logic [26:0] ram_address, ram_address_e;
   logic [2:0]  ram_cmd, ram_cmd_e;
   logic        ram_en, ram_en_e, ram_rdy;
   logic [63:0] ram_rd_data;
   logic        ram_rd_data_valid, ram_rd_data_end, e_zero;
   logic [15:0] out_data, out_data_e;
   logic        out_valid, out_valid_e, out_ready;
   logic        busy, busy_e, done, done_e, rd_error, rd_error_e;

   always #5 clk = ~clk;

   ddr3_stream_reader #(.START_ADDR(S_ADDR), .END_ADDR(E_ADDR), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk(clk), .reset(reset), .start(start), .ram_init_done(ram_init_done),
      .ram_address(ram_address), .ram_cmd(ram_cmd), .ram_en(ram_en), .ram_rdy(ram_rdy),
      .ram_rd_data(ram_rd_data), .ram_rd_data_valid(ram_rd_data_valid),
      .ram_rd_data_end(ram_rd_data_end), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .rd_error(rd_error)
   );

   ddr3_stream_reader #(.START_ADDR(27'd8), .END_ADDR(27'd8), .FIFO_DEPTH(DEPTH)) u_empty (
      .clk(clk), .reset(reset), .start(start_e), .ram_init_done(ram_init_done),
      .ram_address(ram_address_e), .ram_cmd(ram_cmd_e), .ram_en(ram_en_e), .ram_rdy(ram_rdy),
      .ram_rd_data(ram_rd_data), .ram_rd_data_valid(e_zero),
      .ram_rd_data_end(e_zero), .out_data(out_data_e), .out_valid(out_valid_e),
      .out_ready(out_ready), .busy(busy_e), .done(done_e), .rd_error(rd_error_e)
   );

   int          tests_run = 0;
   int          tests_failed = 0;
   int          rdy_mode, ready_mode;
   int          n_cmds, n_words, exp_cmd_addr, exp_word;
   int          addr_q[$];
   int          cur_addr;
   bit          beat_phase, hold_pend, mig_on;
   logic [15:0] hold_val;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory contents: an odd multiplier keeps every word in range distinct.
   function automatic logic [15:0] mem_word(input int w);
      return 16'(w * 40503 + 4660);
   endfunction

   function automatic logic [63:0] beat_lo(input int a);
      return {mem_word(a + 3), mem_word(a + 2), mem_word(a + 1), mem_word(a)};
   endfunction

   function automatic logic [63:0] beat_hi(input int a);
      return {mem_word(a + 7), mem_word(a + 6), mem_word(a + 5), mem_word(a + 4)};
   endfunction

   function automatic logic pick(input int m);
      if (m == 0) return 1'b0;
      if (m == 1) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock of the environment: sample outputs, drive beats and handshakes.
   task automatic step();
      @(negedge clk);
      if (hold_pend && out_valid) check_eq("hold", 64'(out_data), 64'(hold_val));
      if (mig_on) begin
         if (beat_phase) begin
            ram_rd_data_valid = 1'b1;
            ram_rd_data_end   = 1'b1;
            ram_rd_data       = beat_lo(cur_addr);
            beat_phase        = 1'b0;
         end else if (addr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            cur_addr          = addr_q.pop_front();
            ram_rd_data_valid = 1'b1;
            ram_rd_data_end   = 1'b0;
            ram_rd_data       = beat_hi(cur_addr);
            beat_phase        = 1'b1;
         end else begin
            ram_rd_data_valid = 1'b0;
            ram_rd_data_end   = 1'b0;
         end
      end
      ram_rdy   = pick(rdy_mode);
      out_ready = pick(ready_mode);
      if (ram_en && ram_rdy) begin
         check_eq("cmd_addr", 64'(ram_address), 64'(exp_cmd_addr));
         addr_q.push_back(int'(ram_address));
         exp_cmd_addr += 8;
         n_cmds++;
      end
      if (out_valid && out_ready) begin
         check_eq("word", 64'(out_data), 64'(mem_word(exp_word)));
         exp_word++;
         n_words++;
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = out_data;
   endtask

   task automatic begin_pass();
      n_cmds       = 0;
      n_words      = 0;
      exp_cmd_addr = int'(S_ADDR);
      exp_word     = int'(S_ADDR);
      start        = 1'b1;
      step();
      start        = 1'b0;
   endtask

   task automatic run_to_done(input string tag, input int restart_at);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         start = (i == restart_at);
         step();
         start = 1'b0;
         if (done) begin
            found = 1'b1;
            break;
         end
      end
      check_eq({tag, "_done"}, 64'(found), 64'd1);
      check_eq({tag, "_words"}, 64'(n_words), 64'(N_WORDS));
      check_eq({tag, "_cmds"}, 64'(n_cmds), 64'(N_CMDS));
      check_eq({tag, "_rd_error"}, 64'(rd_error), 64'd0);
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic clear_model();
      ram_rd_data_valid = 1'b0;
      ram_rd_data_end   = 1'b0;
      addr_q.delete();
      beat_phase        = 1'b0;
      hold_pend         = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ram_en"}, 64'(ram_en), 64'd0);
      check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
      check_eq({tag, "_done"}, 64'(done), 64'd0);
      check_eq({tag, "_rd_error"}, 64'(rd_error), 64'd0);
      check_eq({tag, "_ram_address"}, 64'(ram_address), 64'd0);
      check_eq({tag, "_out_data"}, 64'(out_data), 64'd0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; start_e = 1'b0; ram_init_done = 1'b0;
      ram_rdy = 1'b0; ram_rd_data = 64'd0; ram_rd_data_valid = 1'b0;
      ram_rd_data_end = 1'b0; e_zero = 1'b0; out_ready = 1'b0;
      rdy_mode = 0; ready_mode = 0; mig_on = 1'b1;
      n_cmds = 0; n_words = 0; exp_cmd_addr = 0; exp_word = 0;
      cur_addr = 0; hold_val = 16'd0;
      clear_model();
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      check_eq("rst_ram_cmd", 64'(ram_cmd), 64'd1);
      reset = 1'b1;

      // start without ram_init_done is ignored
      begin_pass();
      repeat (3) step();
      check_eq("init_gate_busy", 64'(busy), 64'd0);
      check_eq("init_gate_cmds", 64'(n_cmds), 64'd0);
      ram_init_done = 1'b1;

      // sink stalled: exactly DEPTH commands, then the command port closes
      rdy_mode = 1; ready_mode = 0;
      begin_pass();
      repeat (40) step();
      check_eq("stall_cmds", 64'(n_cmds), 64'(DEPTH));
      check_eq("stall_ram_en", 64'(ram_en), 64'd0);
      check_eq("stall_out_valid", 64'(out_valid), 64'd1);
      check_eq("stall_busy", 64'(busy), 64'd1);
      rdy_mode = 2; ready_mode = 2;
      run_to_done("pass1", -1);

      // re-arm from DONE, with a start pulse mid-pass that must be ignored
      begin_pass();
      run_to_done("pass2", 20);

      // empty range goes straight to DONE
      start_e = 1'b1;
      step();
      start_e = 1'b0;
      check_eq("empty_busy", 64'(busy_e), 64'd0);
      check_eq("empty_ram_en", 64'(ram_en_e), 64'd0);
      step();
      check_eq("empty_done", 64'(done_e), 64'd1);
      check_eq("empty_ram_en2", 64'(ram_en_e), 64'd0);
      check_eq("empty_out_valid", 64'(out_valid_e), 64'd0);
      check_eq("empty_rd_error", 64'(rd_error_e), 64'd0);
      check_eq("empty_ram_cmd", 64'(ram_cmd_e), 64'd1);

      // reset after three commands, then replay from the start address
      rdy_mode = 1; ready_mode = 1;
      begin_pass();
      for (int i = 0; i < 50 && n_cmds < 3; i++) step();
      check_eq("abort_cmds", 64'(n_cmds), 64'd3);
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_model();
      #1;
      check_reset_outputs("abort");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rdy_mode = 2; ready_mode = 2;
      begin_pass();
      run_to_done("replay", -1);

      // stray end beat while idle is sticky until reset
      mig_on = 1'b0;
      @(negedge clk);
      ram_rd_data_valid = 1'b1;
      ram_rd_data_end   = 1'b1;
      @(negedge clk);
      ram_rd_data_valid = 1'b0;
      ram_rd_data_end   = 1'b0;
      check_eq("stray_end_err", 64'(rd_error), 64'd1);
      repeat (5) @(negedge clk);
      check_eq("stray_err_sticky", 64'(rd_error), 64'd1);
      check_eq("stray_done_kept", 64'(done), 64'd1);
      reset = 1'b0;
      #1;
      check_eq("err_cleared", 64'(rd_error), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // stray first beat after reset release also flags
      @(negedge clk);
      ram_rd_data_valid = 1'b1;
      ram_rd_data_end   = 1'b0;
      @(negedge clk);
      ram_rd_data_valid = 1'b0;
      check_eq("stray_first_err", 64'(rd_error), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
